imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- UART-fed boot controller that sequences the instruction memory write port and holds the RISC-V core out of execution until a program image has loaded.
- Consumes a byte stream from the UART receiver (rx path), parses a framed image, and issues word writes to instr_memory (wr_en / wr_instr / address).
- Releases core_hold only after a checksum-verified load.
- Re-arms on a new sync byte, so the core can be reloaded without a board reset.

Parameters:
- IMEM_WORDS, 256, instruction memory depth in 32-bit words; maximum accepted image length.
- TIMEOUT_CYCLES, 1000000, maximum idle clock cycles between bytes inside a frame before abort.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- rx_data  input  8  received byte from UART receiver
- rx_valid  input  1  one-cycle strobe; rx_data valid this cycle; may assert every cycle
- imem_wr_en  output  1  instruction memory write strobe, one cycle per word
- imem_wr_addr  output  32  byte address of write, word aligned (word_index*4)
- imem_wr_data  output  32  instruction word to write
- core_hold  output  1  1 = core held in reset/stalled; 0 = core runs
- load_done  output  1  one-cycle pulse on successful load
- load_err  output  1  sticky error flag
- state_dbg  output  3  current FSM state encoding, for debug LEDs

Behaviour:
- Reset (clk edge with rst=1):
  - state=IDLE, core_hold=1, imem_wr_en=0, imem_wr_addr=0, imem_wr_data=0, load_done=0, load_err=0.
  - Internal counters cleared.
  - Reset mid-frame abandons the frame; memory writes already issued are not undone.
- Frame format:
  - SYNC_BYTE, LEN_LO, LEN_HI, then LEN*4 payload bytes as little-endian words, then one CHK byte.
  - CHK = XOR of every byte after SYNC, including both length bytes.
- FSM states: IDLE, LEN_LO, LEN_HI, PAYLOAD, CHECK, RUN.
  - IDLE: core_hold=1. rx_valid with rx_data==SYNC_BYTE -> LEN_LO, clear load_err, clear checksum and word index. Other bytes are ignored.
  - LEN_LO: byte latched as len[7:0] -> LEN_HI.
  - LEN_HI: byte latched as len[15:8]. If len==0 or len>IMEM_WORDS -> load_err=1, IDLE. Otherwise -> PAYLOAD.
  - PAYLOAD: bytes are shifted into the word little-endian, first byte -> [7:0]. On the 4th byte, in the following cycle:
    - imem_wr_en=1 for exactly one cycle;
    - imem_wr_data = assembled word;
    - imem_wr_addr = word_index*4;
    - word_index increments.
    - After word len-1 is written -> CHECK.
  - CHECK: next byte is compared against the running XOR.
    - Match -> RUN, with load_done pulsed for one cycle in the first RUN cycle.
    - Mismatch -> load_err=1, IDLE.
  - RUN: core_hold=0. rx_valid with SYNC_BYTE -> core_hold=1 in the next cycle, -> LEN_LO (reload). Other bytes are ignored.
- Latency: imem_wr_en is asserted exactly 1 cycle after the rx_valid carrying a word's 4th byte. Back-to-back rx_valid must not drop bytes or writes.
- Timeout:
  - The counter runs in LEN_LO, LEN_HI, PAYLOAD and CHECK, and clears on every rx_valid.
  - When the counter reaches TIMEOUT_CYCLES-1 without rx_valid: load_err=1, IDLE.
  - If a timeout and rx_valid coincide, the byte wins and there is no error.
- Outside PAYLOAD, imem_wr_en=0 always. imem_wr_addr and imem_wr_data hold their last values when not writing.
- core_hold is never 0 in any state other than RUN.
- load_err stays asserted until the next accepted SYNC byte in IDLE or RUN.
- A failed load leaves partial memory contents; core_hold stays 1.
- SYNC_BYTE received inside a frame is treated as data, not as a restart.
- Width rules:
  - word_index is 16 bits.
  - imem_wr_addr = {14'b0, word_index, 2'b00}; word_index < IMEM_WORDS guaranteed by the length check.

Test Plan:
- Reset then stream A5,02,00,93,00,50,00,13,01,10,00,C3 -> writes (addr 0x0, data 0x00500093) and (addr 0x4, data 0x00100113); load_done pulses once; core_hold falls to 0 the same cycle; load_err=0.
- Same stream with CHK=C4 -> both writes occur; load_err=1; core_hold stays 1; state IDLE. Resend the correct frame -> load_err clears on A5; load succeeds.
- Length tests, with IMEM_WORDS=256:
  - A5,00,00 -> load_err=1, no writes.
  - A5,01,01 (len=257) -> load_err=1, no writes.
  - A5,00,01 (len=256) -> accepted; the last write goes to addr 0x3FC.
- Timeout with TIMEOUT_CYCLES=16: send A5,01,00,93 and then stop -> load_err=1 after 16 idle cycles, back in IDLE. A gap of 15 cycles between bytes -> no error.
- Reload from RUN: after a good load, send A5 -> core_hold=1 on the next cycle. A second good one-word frame A5,01,00,13,00,00,00,CHK=12 -> write (addr 0x0, data 0x00000013), then RUN.
- Back-to-back rx_valid every cycle for a 4-word frame -> exactly 4 imem_wr_en pulses, each 1 cycle after its word's 4th byte. Assert rst mid-payload -> all outputs return to reset values the next cycle.

Source files
------------

// File: rtl/imem_loader_if.sv
// Byte stream in, instruction-memory write port and boot status out.
// master = loader side, slave = UART/memory/core side.
interface imem_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        imem_wr_en;
  logic [31:0] imem_wr_addr;
  logic [31:0] imem_wr_data;
  logic        core_hold;
  logic        load_done;
  logic        load_err;
  logic [2:0]  state_dbg;

  modport master (
    input  rx_data, rx_valid,
    output imem_wr_en, imem_wr_addr, imem_wr_data,
    output core_hold, load_done, load_err, state_dbg
  );

  modport slave (
    output rx_data, rx_valid,
    input  imem_wr_en, imem_wr_addr, imem_wr_data,
    input  core_hold, load_done, load_err, state_dbg
  );
endinterface

// File: rtl/imem_loader.sv
// UART-fed boot loader: parses SYNC/LEN/payload/CHK frames into instruction
// memory word writes and holds the core until a checksum-verified load.
module imem_loader #(
  parameter int unsigned IMEM_WORDS     = 256,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
  input  logic         clk,
  input  logic         rst,
  imem_loader_if.master bus
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned LW = 16;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LEN_LO  = 3'd1,
    S_LEN_HI  = 3'd2,
    S_PAYLOAD = 3'd3,
    S_CHECK   = 3'd4,
    S_RUN     = 3'd5
  } state_t;

  state_t        state, state_n;
  logic [LW-1:0] len, len_n;
  logic [LW-1:0] word_idx, word_idx_n;
  logic [23:0]   word_buf, word_buf_n;
  logic [1:0]    byte_cnt, byte_cnt_n;
  logic [7:0]    chk, chk_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic          wr_en, wr_en_n;
  logic [31:0]   wr_addr, wr_addr_n;
  logic [31:0]   wr_data, wr_data_n;
  logic          core_hold, core_hold_n;
  logic          load_done, load_done_n;
  logic          load_err, load_err_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      len       <= '0;
      word_idx  <= '0;
      word_buf  <= '0;
      byte_cnt  <= '0;
      chk       <= '0;
      tcnt      <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      core_hold <= 1'b1;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      state     <= state_n;
      len       <= len_n;
      word_idx  <= word_idx_n;
      word_buf  <= word_buf_n;
      byte_cnt  <= byte_cnt_n;
      chk       <= chk_n;
      tcnt      <= tcnt_n;
      wr_en     <= wr_en_n;
      wr_addr   <= wr_addr_n;
      wr_data   <= wr_data_n;
      core_hold <= core_hold_n;
      load_done <= load_done_n;
      load_err  <= load_err_n;
    end
  end

  logic          in_frame;
  logic          timed_out;
  logic          is_sync;
  logic [LW-1:0] len_full;

  always_comb begin
    state_n     = state;
    len_n       = len;
    word_idx_n  = word_idx;
    word_buf_n  = word_buf;
    byte_cnt_n  = byte_cnt;
    chk_n       = chk;
    tcnt_n      = '0;
    wr_en_n     = 1'b0;
    wr_addr_n   = wr_addr;
    wr_data_n   = wr_data;
    load_done_n = 1'b0;
    load_err_n  = load_err;

    is_sync   = bus.rx_valid && (bus.rx_data == SYNC_BYTE);
    len_full  = {bus.rx_data, len[7:0]};
    in_frame  = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                (state == S_PAYLOAD) || (state == S_CHECK);
    // A byte arriving on the expiry cycle rescues the frame.
    timed_out = in_frame && !bus.rx_valid && (tcnt == TW'(TIMEOUT_CYCLES - 1));

    if (in_frame && !bus.rx_valid) begin
      tcnt_n = tcnt + TW'(1);
    end

    case (state)
      S_IDLE, S_RUN: begin
        if (is_sync) begin
          state_n    = S_LEN_LO;
          load_err_n = 1'b0;
          chk_n      = '0;
          word_idx_n = '0;
          byte_cnt_n = '0;
        end
      end
      S_LEN_LO: begin
        if (bus.rx_valid) begin
          len_n   = {8'h00, bus.rx_data};
          chk_n   = chk ^ bus.rx_data;
          state_n = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (bus.rx_valid) begin
          len_n      = len_full;
          chk_n      = chk ^ bus.rx_data;
          byte_cnt_n = '0;
          if ((len_full == '0) || ({16'h0000, len_full} > IMEM_WORDS)) begin
            load_err_n = 1'b1;
            state_n    = S_IDLE;
          end else begin
            state_n = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (bus.rx_valid) begin
          chk_n      = chk ^ bus.rx_data;
          byte_cnt_n = byte_cnt + 2'd1;
          case (byte_cnt)
            2'd0: word_buf_n[7:0]   = bus.rx_data;
            2'd1: word_buf_n[15:8]  = bus.rx_data;
            2'd2: word_buf_n[23:16] = bus.rx_data;
            default: begin
              wr_en_n    = 1'b1;
              wr_data_n  = {bus.rx_data, word_buf};
              wr_addr_n  = {14'b0, word_idx, 2'b00};
              word_idx_n = word_idx + 16'd1;
              if (word_idx == (len - 16'd1)) begin
                state_n = S_CHECK;
              end
            end
          endcase
        end
      end
      S_CHECK: begin
        if (bus.rx_valid) begin
          if (bus.rx_data == chk) begin
            state_n     = S_RUN;
            load_done_n = 1'b1;
          end else begin
            load_err_n = 1'b1;
            state_n    = S_IDLE;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase

    if (timed_out) begin
      state_n    = S_IDLE;
      load_err_n = 1'b1;
      tcnt_n     = '0;
    end

    // Core runs only while sitting in RUN.
    core_hold_n = (state_n != S_RUN);
  end

  assign bus.imem_wr_en   = wr_en;
  assign bus.imem_wr_addr = wr_addr;
  assign bus.imem_wr_data = wr_data;
  assign bus.core_hold    = core_hold;
  assign bus.load_done    = load_done;
  assign bus.load_err     = load_err;
  assign bus.state_dbg    = state;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: expected writes are queued as bytes are
// driven and matched (address, data, cycle) against captured write strobes.
module tb_imem_loader;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  imem_loader_if bus();

  imem_loader #(
    .IMEM_WORDS     (256),
    .TIMEOUT_CYCLES (16),
    .SYNC_BYTE      (8'hA5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] cyc;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         got_q[$];
  int          errors = 0;
  int          checks = 0;
  int          done_cnt = 0;
  logic [31:0] cyc = '0;
  logic [7:0]  run_chk;

  always @(posedge clk) cyc <= cyc + 32'd1;

  // Capture every write strobe and done pulse with the cycle it was seen in.
  always @(negedge clk) begin
    if (bus.imem_wr_en === 1'b1) got_q.push_back({bus.imem_wr_addr, bus.imem_wr_data, cyc});
    if (bus.load_done === 1'b1) done_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_body(input logic [7:0] b);
    run_chk = run_chk ^ b;
    send_byte(b);
  endtask

  task automatic send_word(input logic [31:0] addr, input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) exp_q.push_back({addr, w, cyc + 32'd1});
      send_body(w[8*i +: 8]);
    end
  endtask

  task automatic begin_frame(input logic [15:0] len);
    send_byte(8'hA5);
    run_chk = 8'h00;
    send_body(len[7:0]);
    send_body(len[15:8]);
  endtask

  task automatic check_writes(input string tag);
    wr_t e, g;
    #1;
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s write_count: got %0d expected %0d", tag, got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL %s write: got addr=%h data=%h cyc=%0d expected addr=%h data=%h cyc=%0d",
                 tag, g.addr, g.data, g.cyc, e.addr, e.data, e.cyc);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.core_hold, bus.imem_wr_en, bus.load_done, bus.load_err, bus.state_dbg} !== 7'b1000_000) begin
      errors++;
      $display("FAIL reset flags: got hold=%b wr_en=%b done=%b err=%b state=%0d expected 1 0 0 0 0",
               bus.core_hold, bus.imem_wr_en, bus.load_done, bus.load_err, bus.state_dbg);
    end
    checks++;
    if ({bus.imem_wr_addr, bus.imem_wr_data} !== 64'h0) begin
      errors++;
      $display("FAIL reset addr_data: got %h %h expected 0 0", bus.imem_wr_addr, bus.imem_wr_data);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic_load();
    int d0 = done_cnt;
    begin_frame(16'd2);
    send_word(32'h0, 32'h00500093);
    send_word(32'h4, 32'h00100113);
    send_byte(8'hC3);
    checks++;
    if ({bus.load_done, bus.core_hold, bus.load_err, bus.state_dbg} !== 6'b10_0_101) begin
      errors++;
      $display("FAIL basic first_run: got done=%b hold=%b err=%b state=%0d expected 1 0 0 5",
               bus.load_done, bus.core_hold, bus.load_err, bus.state_dbg);
    end
    @(negedge clk);
    checks++;
    if (bus.load_done !== 1'b0 || bus.core_hold !== 1'b0) begin
      errors++;
      $display("FAIL basic done_pulse: got done=%b hold=%b expected 0 0", bus.load_done, bus.core_hold);
    end
    checks++;
    if (done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL basic done_count: got %0d expected 1", done_cnt - d0);
    end
    check_writes("basic");
  endtask

  task automatic test_bad_checksum();
    int d0 = done_cnt;
    begin_frame(16'd2);
    send_word(32'h0, 32'h00500093);
    send_word(32'h4, 32'h00100113);
    send_byte(8'hC4);
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.load_err, bus.core_hold, bus.state_dbg} !== 5'b11_000) begin
      errors++;
      $display("FAIL badchk status: got err=%b hold=%b state=%0d expected 1 1 0",
               bus.load_err, bus.core_hold, bus.state_dbg);
    end
    checks++;
    if (done_cnt != d0) begin
      errors++;
      $display("FAIL badchk done_count: got %0d expected 0", done_cnt - d0);
    end
    check_writes("badchk");
    send_byte(8'hA5);
    checks++;
    if (bus.load_err !== 1'b0) begin
      errors++;
      $display("FAIL badchk err_clear: got %b expected 0", bus.load_err);
    end
    run_chk = 8'h00;
    send_body(8'h02);
    send_body(8'h00);
    send_word(32'h0, 32'h00500093);
    send_word(32'h4, 32'h00100113);
    send_byte(8'hC3);
    checks++;
    if ({bus.core_hold, bus.load_err, bus.state_dbg} !== 5'b00_101) begin
      errors++;
      $display("FAIL badchk retry: got hold=%b err=%b state=%0d expected 0 0 5",
               bus.core_hold, bus.load_err, bus.state_dbg);
    end
    check_writes("badchk_retry");
  endtask

  task automatic test_length();
    logic [15:0] bad_len [2];
    bad_len = '{16'h0000, 16'h0101};
    for (int k = 0; k < 2; k++) begin
      begin_frame(bad_len[k]);
      checks++;
      if ({bus.load_err, bus.core_hold, bus.state_dbg} !== 5'b11_000) begin
        errors++;
        $display("FAIL length reject len=%h: got err=%b hold=%b state=%0d expected 1 1 0",
                 bad_len[k], bus.load_err, bus.core_hold, bus.state_dbg);
      end
      check_writes("length_reject");
    end
    begin_frame(16'h0100);
    for (int i = 0; i < 256; i++) send_word(32'(i * 4), $urandom);
    send_byte(run_chk);
    checks++;
    if ({bus.load_done, bus.core_hold, bus.load_err} !== 3'b100) begin
      errors++;
      $display("FAIL length max_load: got done=%b hold=%b err=%b expected 1 0 0",
               bus.load_done, bus.core_hold, bus.load_err);
    end
    #1;
    checks++;
    if (got_q.size() == 0 || got_q[got_q.size()-1].addr !== 32'h3FC) begin
      errors++;
      $display("FAIL length last_addr: got %h expected 000003fc",
               (got_q.size() == 0) ? 32'hx : got_q[got_q.size()-1].addr);
    end
    check_writes("length_max");
  endtask

  task automatic test_timeout();
    logic [7:0] gb [7];
    begin_frame(16'd1);
    send_body(8'h93);
    repeat (15) @(negedge clk);
    checks++;
    if (bus.load_err !== 1'b0 || bus.state_dbg !== 3'd3) begin
      errors++;
      $display("FAIL timeout early: got err=%b state=%0d expected 0 3", bus.load_err, bus.state_dbg);
    end
    @(negedge clk);
    checks++;
    if ({bus.load_err, bus.core_hold, bus.state_dbg} !== 5'b11_000) begin
      errors++;
      $display("FAIL timeout expire: got err=%b hold=%b state=%0d expected 1 1 0",
               bus.load_err, bus.core_hold, bus.state_dbg);
    end
    check_writes("timeout");
    gb = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h12};
    send_byte(8'hA5);
    repeat (15) @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      if (i == 5) exp_q.push_back({32'h0, 32'h00000013, cyc + 32'd1});
      send_byte(gb[i]);
      if (i < 6) repeat (15) @(negedge clk);
    end
    checks++;
    if ({bus.load_err, bus.core_hold, bus.state_dbg} !== 5'b00_101) begin
      errors++;
      $display("FAIL timeout gap15: got err=%b hold=%b state=%0d expected 0 0 5",
               bus.load_err, bus.core_hold, bus.state_dbg);
    end
    check_writes("timeout_gap");
  endtask

  task automatic test_reload();
    send_byte(8'hA5);
    checks++;
    if (bus.core_hold !== 1'b1 || bus.state_dbg !== 3'd1) begin
      errors++;
      $display("FAIL reload hold: got hold=%b state=%0d expected 1 1", bus.core_hold, bus.state_dbg);
    end
    send_byte(8'h01);
    send_byte(8'h00);
    send_word(32'h0, 32'h00000013);
    send_byte(8'h12);
    checks++;
    if ({bus.load_done, bus.core_hold, bus.state_dbg} !== 5'b10_101) begin
      errors++;
      $display("FAIL reload run: got done=%b hold=%b state=%0d expected 1 0 5",
               bus.load_done, bus.core_hold, bus.state_dbg);
    end
    check_writes("reload");
  endtask

  task automatic test_back_to_back();
    int d0 = done_cnt;
    begin_frame(16'd4);
    for (int i = 0; i < 4; i++) send_word(32'(i * 4), $urandom);
    send_byte(run_chk);
    @(negedge clk);
    checks++;
    if (done_cnt - d0 != 1 || bus.core_hold !== 1'b0) begin
      errors++;
      $display("FAIL b2b done: got done_count=%0d hold=%b expected 1 0", done_cnt - d0, bus.core_hold);
    end
    check_writes("b2b");
  endtask

  task automatic test_reset_mid();
    begin_frame(16'd4);
    send_word(32'h0, 32'hDEADBEEF);
    send_body(8'h11);
    send_body(8'h22);
    rst = 1'b1;
    bus.rx_data  = 8'h33;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    checks++;
    if ({bus.core_hold, bus.imem_wr_en, bus.load_done, bus.load_err, bus.state_dbg} !== 7'b1000_000) begin
      errors++;
      $display("FAIL midrst flags: got hold=%b wr_en=%b done=%b err=%b state=%0d expected 1 0 0 0 0",
               bus.core_hold, bus.imem_wr_en, bus.load_done, bus.load_err, bus.state_dbg);
    end
    checks++;
    if ({bus.imem_wr_addr, bus.imem_wr_data} !== 64'h0) begin
      errors++;
      $display("FAIL midrst addr_data: got %h %h expected 0 0", bus.imem_wr_addr, bus.imem_wr_data);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_writes("midrst");
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_bad_checksum();
    test_length();
    test_timeout();
    test_reload();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
